uart_rx: RTL

- UART serial receiver that sits directly upstream of the BIP host interface FSM.
- Deserializes 8N1 frames (or 8E1 with the optional feature) from the rx pin using 16x oversampling from an internal baud-tick generator.
- Presents each received byte on rx_data_out with a one-cycle rx_done_tick; the interface FSM edge-detects that pulse to start the CPU.

---
 rtl/uart_rx.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver, 16x oversampled from an internal baud-tick divider.
// Define UART_RX_PARITY_EN to add one even-parity bit between data and stop.
module uart_rx #(
  parameter int NBIT_DATA_LEN = 8,
  parameter int SB_TICK       = 16,
  parameter int BAUD_DIV      = 163
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rx,
  output logic [NBIT_DATA_LEN-1:0] rx_data_out,
  output logic                     rx_done_tick,
  output logic                     frame_err,
  output logic                     parity_err
);
  localparam int BW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int NW = (NBIT_DATA_LEN > 1) ? $clog2(NBIT_DATA_LEN) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [SW-1:0] S_MID     = SW'(7);
  localparam logic [SW-1:0] S_BIT     = SW'(15);
  localparam logic [SW-1:0] S_STOP    = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST    = NW'(NBIT_DATA_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  // Free-running oversampling tick, independent of the FSM
  logic [BW-1:0] baud_q;
  logic          s_tick;
  assign s_tick = (baud_q == BAUD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) baud_q <= '0;
    else        baud_q <= s_tick ? '0 : baud_q + BW'(1);
  end

  logic [1:0] sync_q;
  logic       rx_s;
  assign rx_s = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], rx};
  end

  state_t                   state_q, state_d;
  logic [SW-1:0]            s_q, s_d;
  logic [NW-1:0]            n_q, n_d;
  logic [NBIT_DATA_LEN-1:0] sreg_q, sreg_d;
  logic [NBIT_DATA_LEN-1:0] data_q, data_d;
  logic                     done_q, done_d;
  logic                     ferr_q, ferr_d;
  // Cleared after a low stop bit so a held-low line cannot restart a frame
  logic                     armed_q, armed_d;
`ifdef UART_RX_PARITY_EN
  logic                     par_q, par_d;
  logic                     perr_q, perr_d;
  logic                     parity_ok;
  assign parity_ok = ~(^{sreg_q, par_q});
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      sreg_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      armed_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      sreg_q  <= sreg_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      armed_q <= armed_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    sreg_d  = sreg_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    armed_d = armed_q;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (rx_s) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == S_MID) begin
            if (!rx_s) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == S_BIT) begin
            s_d    = '0;
            sreg_d = {rx_s, sreg_q[NBIT_DATA_LEN-1:1]};
            if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (s_q == S_BIT) begin
            s_d     = '0;
            par_d   = rx_s;
            state_d = STOP;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (s_q == S_STOP) begin
            state_d = IDLE;
            if (!rx_s) begin
              ferr_d  = 1'b1;
              armed_d = 1'b0;
`ifdef UART_RX_PARITY_EN
            end else if (!parity_ok) begin
              perr_d = 1'b1;
`endif
            end else begin
              data_d = sreg_q;
              done_d = 1'b1;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_data_out  = data_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err   = perr_q;
`else
  assign parity_err   = 1'b0;
`endif

endmodule
